div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions. Sits in the execute stage beside the ALU: it accepts operands and `div_control` from decode/execute, runs one restoring-division step per cycle, and presents all four result views to the execute-commit stage. The commit stage selects one view by `div_control` and releases the result with `div_rsp_ready`.

## Interface
- `DATA_WIDTH`, default 32: operand and result width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `div_req_valid` in 1: request present.
- `div_req_ready` out 1: unit can accept a request; high only in IDLE.
- `div_control` in 3: op encoding.
  - 3'b110 DIV
  - 3'b010 DIVU
  - 3'b101 REM
  - 3'b001 REMU
  - 3'b000 is no request; other codes are not issued.
- `dividend`, `divisor` in DATA_WIDTH: rs1 and rs2.
- `div_flush` in 1: kills any in-flight operation.
- `div_type_ok` out 1: response valid.
- `div_rsp_ready` in 1: consumer takes the response.
- `signed_div_res`, `unsigned_div_res`, `signed_rem_res`, `unsigned_rem_res` out DATA_WIDTH: result views. They are stable while `div_type_ok` is high.

## Operation
- **Accept:** on `div_req_valid && div_req_ready && !div_flush`:
  - Latch `div_control[2]` as the `is_signed` flag.
  - Latch the operand signs `sa = dividend[31] & is_signed` and `sb = divisor[31] & is_signed`.
  - Latch the magnitudes: `|a|` = two's-complement negate when `sa`, else raw; same for `|b|`.
- **Divisor == 0:** next state is DONE. Outputs are:
  - Quotient views = all ones (0xFFFFFFFF).
  - Remainder views = the raw dividend.
- **Otherwise BUSY:**
  - Registers: `rem` (DATA_WIDTH+1 bits) = 0, `quo` = `|a|`, 6-bit `cnt` = 0.
  - Each cycle: shift `{rem,quo}` left by 1, then trial = `rem − {0,|b|}`.
  - If trial is non-negative: `rem` = trial, `quo[0]` = 1. Otherwise `quo[0]` = 0.
  - `cnt` increments; after the DATA_WIDTH-th step, go to FIX.
- **FIX (1 cycle):**
  - `unsigned_div_res` = `quo`; `unsigned_rem_res` = `rem[DATA_WIDTH-1:0]`.
  - `signed_div_res` = `quo`, negated when `sa ^ sb`.
  - `signed_rem_res` = `rem`, negated when `sa`. The remainder takes the dividend's sign.
  - For unsigned ops, `sa = sb = 0`, so the signed views equal the unsigned views.
  - Overflow case (−2^31 / −1) falls out naturally: quotient 0x80000000, remainder 0. No special path.
- **DONE:**
  - `div_type_ok` = 1; results held.
  - On `div_rsp_ready`, go to IDLE at the next edge.
  - No new request is accepted in the same cycle; `div_req_ready` stays low in DONE.
- **States:** IDLE → BUSY → FIX → DONE → IDLE, plus IDLE → DONE for a zero divisor.
- **Flush:** `div_flush` forces IDLE at the next edge from any state, dropping the result.
  - Flush has priority over accept and over the response handshake.

## Timing
- **Reset values:**
  - State = IDLE; `div_req_ready` = 1 (decoded from state); `div_type_ok` = 0.
  - All four result outputs = 0; `cnt` = 0.
- **Latency (accept edge = T0):**
  - Normal division: BUSY for edges T1..T32, FIX at T33, `div_type_ok` high from T34 (34 cycles).
  - Zero divisor: `div_type_ok` high from T1.
- **Throughput:** the next request is accepted no earlier than the cycle after the response handshake.
- **Handshake rules:**
  - `div_type_ok` stays high, with results unchanged, until `div_rsp_ready` is sampled high.
  - `div_rsp_ready` is a don't-care outside DONE.
  - `div_req_ready` is purely state-decoded, with no combinational path from `div_req_valid`.
- **Request-side inputs:** `dividend`, `divisor` and `div_control` are sampled only at the accept edge. Later changes have no effect.
- **Reset mid-operation:** asynchronous return to the reset values above. No partial result is visible.
- **Flush and response in the same DONE cycle:** the response counts as discarded; the state goes to IDLE either way.

## Test plan
- DIVU 100 / 7 → after 34 cycles:
  - unsigned_div_res = 14, unsigned_rem_res = 2.
  - Signed views are identical.
  - `div_req_ready` is low throughout.
- DIV −7 / 2 (0xFFFFFFF9, 2) → signed_div_res = 0xFFFFFFFD (−3), signed_rem_res = 0xFFFFFFFF (−1). REM 7 / −2 → signed_rem_res = 1, signed_div_res = 0xFFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF → signed_div_res = 0x80000000, signed_rem_res = 0, latency 34.
- DIVU 5 / 0 and DIV −5 / 0 → `div_type_ok` at T1:
  - Quotient views = 0xFFFFFFFF.
  - Remainder views = 5 and 0xFFFFFFFB respectively.
- Backpressure: hold `div_rsp_ready` = 0 for 10 cycles after `div_type_ok` → outputs stable. Then raise it for 1 cycle → IDLE next edge; a new request is accepted the following cycle.
- Assert `div_flush` at T10 of a DIV → IDLE at T11, no `div_type_ok`. Then deassert `rst_n` at T5 of another op → all outputs 0 immediately; the next request completes correctly.

Source files
------------

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  div_req_valid,
  output logic                  div_req_ready,
  input  logic [2:0]            div_control,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  div_flush,
  output logic                  div_type_ok,
  input  logic                  div_rsp_ready,
  output logic [DATA_WIDTH-1:0] signed_div_res,
  output logic [DATA_WIDTH-1:0] unsigned_div_res,
  output logic [DATA_WIDTH-1:0] signed_rem_res,
  output logic [DATA_WIDTH-1:0] unsigned_rem_res
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t         state, next_state;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [W-1:0]   abs_b;
  logic           sa, sb;
  logic [5:0]     cnt;

  logic           accept;
  logic           sa_in, sb_in;
  logic [W-1:0]   abs_a_in, abs_b_in;
  logic [W:0]     shifted;
  logic [W:0]     trial;

  assign div_req_ready = (state == S_IDLE);
  assign div_type_ok   = (state == S_DONE);

  // 3'b000 on div_control means no instruction is present
  assign accept   = div_req_valid && div_req_ready && !div_flush && (div_control != 3'b000);
  assign sa_in    = dividend[W-1] & div_control[2];
  assign sb_in    = divisor[W-1] & div_control[2];
  assign abs_a_in = sa_in ? (~dividend + 1'b1) : dividend;
  assign abs_b_in = sb_in ? (~divisor + 1'b1) : divisor;

  // The partial remainder stays below |b|, so one extra bit holds the shifted value and the trial sign
  assign shifted  = {rem, quo[W-1]};
  assign trial    = shifted - {1'b0, abs_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (accept) next_state = (divisor == '0) ? S_DONE : S_BUSY;
      S_BUSY: if (cnt == 6'(W - 1)) next_state = S_FIX;
      S_FIX:  next_state = S_DONE;
      S_DONE: if (div_rsp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (div_flush) next_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem              <= '0;
      quo              <= '0;
      abs_b            <= '0;
      sa               <= 1'b0;
      sb               <= 1'b0;
      cnt              <= '0;
      signed_div_res   <= '0;
      unsigned_div_res <= '0;
      signed_rem_res   <= '0;
      unsigned_rem_res <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            sa    <= sa_in;
            sb    <= sb_in;
            abs_b <= abs_b_in;
            rem   <= '0;
            quo   <= abs_a_in;
            cnt   <= '0;
            if (divisor == '0) begin
              signed_div_res   <= '1;
              unsigned_div_res <= '1;
              signed_rem_res   <= dividend;
              unsigned_rem_res <= dividend;
            end
          end
        end
        S_BUSY: begin
          if (!trial[W]) rem <= trial[W-1:0];
          else           rem <= shifted[W-1:0];
          quo <= {quo[W-2:0], ~trial[W]};
          cnt <= cnt + 6'd1;
        end
        S_FIX: begin
          unsigned_div_res <= quo;
          unsigned_rem_res <= rem;
          signed_div_res   <= (sa ^ sb) ? (~quo + 1'b1) : quo;
          signed_rem_res   <= sa ? (~rem + 1'b1) : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_req_valid = 1'b0;
  logic        div_req_ready;
  logic [2:0]  div_control = 3'b000;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        div_flush = 1'b0;
  logic        div_type_ok;
  logic        div_rsp_ready = 1'b0;
  logic [31:0] signed_div_res, unsigned_div_res, signed_rem_res, unsigned_rem_res;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] OP_DIV  = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b010;
  localparam logic [2:0] OP_REM  = 3'b101;
  localparam logic [2:0] OP_REMU = 3'b001;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .div_req_valid(div_req_valid), .div_req_ready(div_req_ready),
    .div_control(div_control), .dividend(dividend), .divisor(divisor),
    .div_flush(div_flush), .div_type_ok(div_type_ok), .div_rsp_ready(div_rsp_ready),
    .signed_div_res(signed_div_res), .unsigned_div_res(unsigned_div_res),
    .signed_rem_res(signed_rem_res), .unsigned_rem_res(unsigned_rem_res)
  );

  always #5 clk = ~clk;

  // Drive one request through its accept edge, then scramble operands to prove they were latched
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    div_req_valid = 1'b1;
    div_control   = op;
    dividend      = a;
    divisor       = b;
    @(posedge clk);
    #1;
    div_req_valid = 1'b0;
    div_control   = 3'b000;
    dividend      = 32'hDEAD_BEEF;
    divisor       = 32'h0000_0003;
  endtask

  task automatic wait_ok(output int lat, output logic ready_seen);
    lat = 0;
    ready_seen = div_req_ready;
    while (!div_type_ok && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (div_req_ready) ready_seen = 1'b1;
    end
    if (!div_type_ok) lat = -1;
  endtask

  task automatic release_rsp();
    @(negedge clk);
    div_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    div_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (div_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", div_req_ready); end
    checks++; if (div_type_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b want 0", div_type_ok); end
    checks++; if (signed_div_res !== 32'h0) begin errors++; $display("FAIL reset_sdiv: got %h want 0", signed_div_res); end
    checks++; if (unsigned_div_res !== 32'h0) begin errors++; $display("FAIL reset_udiv: got %h want 0", unsigned_div_res); end
    checks++; if (signed_rem_res !== 32'h0) begin errors++; $display("FAIL reset_srem: got %h want 0", signed_rem_res); end
    checks++; if (unsigned_rem_res !== 32'h0) begin errors++; $display("FAIL reset_urem: got %h want 0", unsigned_rem_res); end
  endtask

  task automatic test_divu();
    int lat; logic rs;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_ok(lat, rs);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL divu_ready_low: got %b want 0", rs); end
    checks++; if (unsigned_div_res !== 32'd14) begin errors++; $display("FAIL divu_udiv: got %h want 0000000e", unsigned_div_res); end
    checks++; if (unsigned_rem_res !== 32'd2) begin errors++; $display("FAIL divu_urem: got %h want 00000002", unsigned_rem_res); end
    checks++; if (signed_div_res !== 32'd14) begin errors++; $display("FAIL divu_sdiv: got %h want 0000000e", signed_div_res); end
    checks++; if (signed_rem_res !== 32'd2) begin errors++; $display("FAIL divu_srem: got %h want 00000002", signed_rem_res); end
    release_rsp();
    checks++; if (div_req_ready !== 1'b1) begin errors++; $display("FAIL divu_back_idle: got %b want 1", div_req_ready); end
  endtask

  task automatic test_signed();
    int lat; logic rs;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_ok(lat, rs);
    checks++; if (signed_div_res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_sdiv: got %h want fffffffd", signed_div_res); end
    checks++; if (signed_rem_res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_srem: got %h want ffffffff", signed_rem_res); end
    release_rsp();
    issue(OP_REM, 32'd7, 32'hFFFF_FFFE);
    wait_ok(lat, rs);
    checks++; if (signed_rem_res !== 32'd1) begin errors++; $display("FAIL rem_negb_srem: got %h want 00000001", signed_rem_res); end
    checks++; if (signed_div_res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL rem_negb_sdiv: got %h want fffffffd", signed_div_res); end
    release_rsp();
  endtask

  task automatic test_overflow();
    int lat; logic rs;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_ok(lat, rs);
    checks++; if (lat !== 33) begin errors++; $display("FAIL ovf_latency: got %0d want 33", lat); end
    checks++; if (signed_div_res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_sdiv: got %h want 80000000", signed_div_res); end
    checks++; if (signed_rem_res !== 32'h0) begin errors++; $display("FAIL ovf_srem: got %h want 00000000", signed_rem_res); end
    release_rsp();
  endtask

  task automatic test_div_zero();
    int lat; logic rs;
    issue(OP_REMU, 32'd5, 32'd0);
    wait_ok(lat, rs);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dz_u_latency: got %0d want 0", lat); end
    checks++; if (unsigned_div_res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_u_udiv: got %h want ffffffff", unsigned_div_res); end
    checks++; if (signed_div_res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_u_sdiv: got %h want ffffffff", signed_div_res); end
    checks++; if (unsigned_rem_res !== 32'd5) begin errors++; $display("FAIL dz_u_urem: got %h want 00000005", unsigned_rem_res); end
    checks++; if (signed_rem_res !== 32'd5) begin errors++; $display("FAIL dz_u_srem: got %h want 00000005", signed_rem_res); end
    release_rsp();
    issue(OP_DIV, 32'hFFFF_FFFB, 32'd0);
    wait_ok(lat, rs);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dz_s_latency: got %0d want 0", lat); end
    checks++; if (signed_div_res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_s_sdiv: got %h want ffffffff", signed_div_res); end
    checks++; if (signed_rem_res !== 32'hFFFF_FFFB) begin errors++; $display("FAIL dz_s_srem: got %h want fffffffb", signed_rem_res); end
    checks++; if (unsigned_rem_res !== 32'hFFFF_FFFB) begin errors++; $display("FAIL dz_s_urem: got %h want fffffffb", unsigned_rem_res); end
    release_rsp();
  endtask

  task automatic test_back_to_back();
    int lat; logic rs;
    issue(OP_DIVU, 32'd1000, 32'd10);
    wait_ok(lat, rs);
    checks++; if (unsigned_div_res !== 32'd100) begin errors++; $display("FAIL bp_udiv: got %h want 00000064", unsigned_div_res); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (div_type_ok !== 1'b1 || unsigned_div_res !== 32'd100 || unsigned_rem_res !== 32'd0 || div_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ok=%b rdy=%b q=%h r=%h want ok=1 rdy=0 q=00000064 r=00000000",
                 i, div_type_ok, div_req_ready, unsigned_div_res, unsigned_rem_res);
      end
    end
    release_rsp();
    checks++; if (div_req_ready !== 1'b1 || div_type_ok !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b ok=%b want rdy=1 ok=0", div_req_ready, div_type_ok); end
    issue(OP_DIVU, 32'd9, 32'd3);
    checks++; if (div_req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: got rdy=%b want 0", div_req_ready); end
    wait_ok(lat, rs);
    checks++; if (lat !== 33 || unsigned_div_res !== 32'd3) begin errors++; $display("FAIL b2b_result: got lat=%0d q=%h want lat=33 q=00000003", lat, unsigned_div_res); end
    release_rsp();
  endtask

  task automatic test_flush();
    logic ok_seen;
    issue(OP_DIV, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    div_flush = 1'b1;
    @(posedge clk);
    #1;
    div_flush = 1'b0;
    checks++; if (div_req_ready !== 1'b1 || div_type_ok !== 1'b0) begin errors++; $display("FAIL flush_idle: got rdy=%b ok=%b want rdy=1 ok=0", div_req_ready, div_type_ok); end
    ok_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (div_type_ok) ok_seen = 1'b1;
    end
    checks++; if (ok_seen !== 1'b0) begin errors++; $display("FAIL flush_no_rsp: got ok_seen=%b want 0", ok_seen); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic rs;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (div_type_ok !== 1'b0 || div_req_ready !== 1'b1 || signed_div_res !== 32'h0 || unsigned_div_res !== 32'h0 ||
        signed_rem_res !== 32'h0 || unsigned_rem_res !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid: got ok=%b rdy=%b sq=%h uq=%h sr=%h ur=%h want ok=0 rdy=1 all results 0",
               div_type_ok, div_req_ready, signed_div_res, unsigned_div_res, signed_rem_res, unsigned_rem_res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(OP_DIVU, 32'd81, 32'd9);
    wait_ok(lat, rs);
    checks++; if (lat !== 33 || unsigned_div_res !== 32'd9 || unsigned_rem_res !== 32'd0) begin
      errors++; $display("FAIL rst_recover: got lat=%0d q=%h r=%h want lat=33 q=00000009 r=00000000", lat, unsigned_div_res, unsigned_rem_res);
    end
    release_rsp();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_divu();
    test_signed();
    test_overflow();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
